alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit bitwise logic units (AND/OR/XOR) and the ALU result mux.
- Captures each combinational result with its opcode tag and computes zero and negative flags.
- Presents results to the consumer over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a fully registered in_ready, so consumer backpressure never reaches the combinational datapath in the same cycle.

Parameters:
- WIDTH, 32, result data width in bits.
- OPW, 4, width of the opcode tag carried alongside each result.
- CNTW, 16, width of the delivered-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; registered.
- in_result  input  WIDTH  result from the logic unit / result mux.
- in_op  input  OPW  opcode tag of that result.
- out_valid  output  1  output entry valid.
- out_ready  input  1  consumer accepts.
- out_result  output  WIDTH  registered result.
- out_op  output  OPW  registered opcode tag.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[WIDTH-1].
- cnt_clr  input  1  synchronous clear of delivered counter.
- delivered  output  CNTW  count of output handshakes, saturating.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Occupancy goes to EMPTY.
  - out_valid, out_result, out_op, out_zero, out_neg, delivered and in_ready all go to 0.
  - in_ready rises to 1 on the first clk edge with rst_n high.
  - Reset mid-transfer discards both entries silently; no partial output.
- Handshakes:
  - Accept = in_valid && in_ready.
  - Deliver = out_valid && out_ready.
  - in_valid may not depend on in_ready.
  - Inputs are ignored when in_ready = 0.
- Occupancy FSM has three states: EMPTY, ONE (main register valid), TWO (main + skid valid).
  - EMPTY: accept -> ONE, entry loaded into the main register.
  - ONE:
    - accept && !deliver -> TWO, entry loaded into skid.
    - accept && deliver -> ONE, main reloaded from input.
    - !accept && deliver -> EMPTY.
  - TWO:
    - deliver -> ONE, main loaded from skid.
    - No accept is possible, since in_ready = 0.
- Output signals:
  - out_valid = (state != EMPTY); registered.
  - in_ready next = (next_state != TWO).
- Latency and throughput:
  - One cycle from accept to out_valid when the stage is empty.
  - Sustained 1 result/cycle when out_ready is held high.
  - Ordering is strictly FIFO.
- Flags:
  - Computed from the incoming data before registering.
  - Stored per entry, so the flags always match out_result.
- While out_valid = 1 and out_ready = 0, out_result, out_op and the flags are held stable.
- delivered counter:
  - Increments by 1 on each deliver.
  - Saturates at 2^CNTW-1.
  - cnt_clr wins over a simultaneous deliver: result is 0.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit), the even parity (XOR reduction) of out_result.
  - Stored per entry alongside the flags.
  - Reset value 0.
- When undefined:
  - The port and its storage are absent.
  - All other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - Constants ALU_WIDTH = 32 and ALU_OPW = 4.
  - Typedef alu_op_t for opcode tags (AND, OR, XOR, ADD, SUB, SLT, NOR, ...).
  - Typedef occ_state_t {EMPTY, ONE, TWO}.
  - Typedef result_entry_t {result, op, zero, neg [, parity]}.
- One sub-module, alu_flag_gen: combinational WIDTH-bit zero/negative (and optional parity) generator, reused by the main and skid entry paths.

Test Plan:
1. Reset then stream: hold out_ready = 1 and send 0xFFFF0000, 0x0000FFFF, 0x80000001 on consecutive cycles.
   - Each appears one cycle later with no bubbles.
   - Flags (zero, neg) = (0,1), (0,0), (0,1).
   - delivered = 3.
2. Backpressure: hold out_ready = 0 and offer three results.
   - Exactly two are accepted; in_ready = 0 from the cycle after the second accept.
   - Output holds the first result stable.
   - Release out_ready: the results drain in order.
3. Zero flag: input 0x00000000 with op AND -> out_zero = 1, out_neg = 0, out_op = AND.
4. Reset mid-transfer: stage in TWO, assert rst_n low for one cycle.
   - out_valid = 0, delivered = 0.
   - in_ready = 0, then 1 on the next cycle.
   - No stale data is delivered afterwards.
5. Counter: preload via 65535 delivers -> counter stays at 65535 on further delivers; cnt_clr concurrent with a deliver -> 0.
6. With ALU_RESULT_PARITY_EN defined: 0x00000007 -> out_parity = 1; 0x00000003 -> out_parity = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU result output stage
// Optional feature macro: ALU_RESULT_PARITY_EN (adds a per-entry parity bit)
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 4;

    typedef enum logic [ALU_OPW-1:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_NOR = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_SLT = 4'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // One buffered result; flags travel with the data so they always match it.
    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_OPW-1:0]   op;
        logic                 zero;
        logic                 neg;
`ifdef ALU_RESULT_PARITY_EN
        logic                 parity;
`endif
    } result_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational zero/negative (and optional parity) flag generator
// Optional feature macro: ALU_RESULT_PARITY_EN
// Ports:
//   i_data   : WIDTH-bit result to classify
//   o_zero   : i_data == 0
//   o_neg    : sign bit of i_data
//   o_parity : XOR reduction of i_data (only with ALU_RESULT_PARITY_EN)
module alu_flag_gen #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
`ifdef ALU_RESULT_PARITY_EN
    output logic             o_parity,
`endif
    output logic             o_zero,
    output logic             o_neg
);

    assign o_zero = (i_data == '0);
    assign o_neg  = i_data[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
    assign o_parity = ^i_data;
`endif

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage with 2-entry skid buffer and flags
// Optional feature macro: ALU_RESULT_PARITY_EN (adds out_parity)
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready is registered)
//   in_result, in_op      : incoming result and its opcode tag
//   out_valid/out_ready   : downstream handshake
//   out_result, out_op    : registered result and tag
//   out_zero, out_neg     : flags of out_result
//   out_parity            : XOR reduction of out_result (optional)
//   cnt_clr, delivered    : clear and value of saturating delivered-result counter
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_neg,
`ifdef ALU_RESULT_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             cnt_clr,
    output logic [CNTW-1:0]  delivered
);

    occ_state_t    r_state;
    occ_state_t    w_next_state;
    result_entry_t r_main;
    result_entry_t r_skid;
    result_entry_t w_in_entry;
    logic          r_out_valid;
    logic          r_in_ready;
    logic [CNTW-1:0] r_delivered;

    logic w_accept;
    logic w_deliver;
    logic w_zero;
    logic w_neg;
`ifdef ALU_RESULT_PARITY_EN
    logic w_parity;
`endif

    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // Flags are computed once on the incoming data; both the main and skid
    // registers load from this same entry, so flags never need recomputing.
    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .i_data   (in_result),
`ifdef ALU_RESULT_PARITY_EN
        .o_parity (w_parity),
`endif
        .o_zero   (w_zero),
        .o_neg    (w_neg)
    );

    always_comb begin
        w_in_entry        = '0;
        w_in_entry.result = in_result;
        w_in_entry.op     = in_op;
        w_in_entry.zero   = w_zero;
        w_in_entry.neg    = w_neg;
`ifdef ALU_RESULT_PARITY_EN
        w_in_entry.parity = w_parity;
`endif
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_next_state = ONE;
            ONE: begin
                if (w_accept && !w_deliver)      w_next_state = TWO;
                else if (!w_accept && w_deliver) w_next_state = EMPTY;
            end
            TWO:     if (w_deliver) w_next_state = ONE;
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_delivered <= '0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != EMPTY);
            // Registered ready: drops only once both entries are occupied.
            r_in_ready  <= (w_next_state != TWO);

            case (r_state)
                EMPTY: if (w_accept) r_main <= w_in_entry;
                ONE: begin
                    if (w_accept && w_deliver) r_main <= w_in_entry;
                    else if (w_accept)         r_skid <= w_in_entry;
                end
                TWO:     if (w_deliver) r_main <= r_skid;
                default: ;
            endcase

            if (cnt_clr)
                r_delivered <= '0;
            else if (w_deliver && (r_delivered != {CNTW{1'b1}}))
                r_delivered <= r_delivered + 1'b1;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_main.result;
    assign out_op     = r_main.op;
    assign out_zero   = r_main.zero;
    assign out_neg    = r_main.neg;
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity = r_main.parity;
`endif
    assign delivered  = r_delivered;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_op;
    logic        out_zero;
    logic        out_neg;
`ifdef ALU_RESULT_PARITY_EN
    logic        out_parity;
`endif
    logic        cnt_clr;
    logic [15:0] delivered;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`ifdef ALU_RESULT_PARITY_EN
        .out_parity (out_parity),
`endif
        .cnt_clr    (cnt_clr),
        .delivered  (delivered)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  op;
        logic        z;
        logic        n;
        logic        p;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'hFFFF0000, OP_AND, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h0000FFFF, OP_OR,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h80000001, OP_XOR, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h00000000, OP_AND, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h00000007, OP_ADD, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h00000003, OP_SUB, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_op = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_result",    64'(out_result), 64'd0);
        chk("rst_flags",     64'({out_zero, out_neg}), 64'd0);
        chk("rst_delivered", 64'(delivered), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready_rise", 64'(in_ready), 64'd1);

        // Streaming with out_ready held high: each result appears one cycle later.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_result = vecs[i].res; in_op = vecs[i].op;
            step();
            chk($sformatf("str%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("str%0d_result", i), 64'(out_result), 64'(vecs[i].res));
            chk($sformatf("str%0d_op", i), 64'(out_op), 64'(vecs[i].op));
            chk($sformatf("str%0d_zn", i), 64'({out_zero, out_neg}), 64'({vecs[i].z, vecs[i].n}));
            chk($sformatf("str%0d_ready", i), 64'(in_ready), 64'd1);
`ifdef ALU_RESULT_PARITY_EN
            chk($sformatf("str%0d_parity", i), 64'(out_parity), 64'(vecs[i].p));
`endif
        end
        in_valid = 1'b0;
        step();
        chk("str_drain_valid", 64'(out_valid), 64'd0);
        chk("str_delivered",   64'(delivered), 64'd6);

        // Backpressure: two accepted, third blocked, output held stable.
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'h11111111; in_op = OP_OR;
        step();
        chk("bp_a_valid", 64'(out_valid), 64'd1);
        chk("bp_a_ready", 64'(in_ready),  64'd1);
        in_result = 32'h22222222; in_op = OP_XOR;
        step();
        chk("bp_b_ready", 64'(in_ready),   64'd0);
        chk("bp_b_hold",  64'(out_result), 64'h11111111);
        in_result = 32'h33333333; in_op = OP_NOR;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("bp_c_hold%0d", k), 64'(out_result), 64'h11111111);
            chk($sformatf("bp_c_op%0d", k),   64'(out_op), 64'(OP_OR));
            chk($sformatf("bp_c_ready%0d", k), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_drain_b",     64'(out_result), 64'h22222222);
        chk("bp_drain_b_op",  64'(out_op), 64'(OP_XOR));
        chk("bp_drain_ready", 64'(in_ready), 64'd1);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);
        step();
        chk("bp_no_c",      64'(out_valid), 64'd0);
        chk("bp_delivered", 64'(delivered), 64'd8);

        // Reset while both entries are occupied.
        out_ready = 1'b0; in_valid = 1'b1;
        in_result = 32'hAAAA5555; in_op = OP_ADD;
        step();
        in_result = 32'h5555AAAA; in_op = OP_SUB;
        step();
        chk("mr_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        chk("mr_valid",     64'(out_valid), 64'd0);
        chk("mr_delivered", 64'(delivered), 64'd0);
        chk("mr_ready0",    64'(in_ready),  64'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("mr_ready1", 64'(in_ready), 64'd1);
        step(); step();
        chk("mr_no_stale",     64'(out_valid), 64'd0);
        chk("mr_no_stale_cnt", 64'(delivered), 64'd0);

        // Saturating counter: 65536 back-to-back accepts give 65535 delivers.
        in_valid = 1'b1; in_result = 32'h12345678; in_op = OP_SLT;
        for (int k = 0; k < 65536; k++) begin
            @(posedge clk);
        end
        #1;
        chk("cnt_max", 64'(delivered), 64'd65535);
        step(); step(); step();
        chk("cnt_sat", 64'(delivered), 64'd65535);
        cnt_clr = 1'b1;
        step();
        chk("cnt_clr_wins", 64'(delivered), 64'd0);
        cnt_clr = 1'b0;
        step();
        chk("cnt_after_clr", 64'(delivered), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
